// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer: state encoding,
// BCD limits and the timer width helper.
package game_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic int timer_width(input int ticks);
        return $clog2(ticks);
    endfunction

endpackage

// File: rtl/game_timer.sv
// Inter-round delay: a load starts a TIMER_TICKS-cycle countdown; done stays
// high once the count reaches zero.
module game_timer
    import game_pkg::*;
#(
    parameter int TIMER_TICKS = 200_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int TW = timer_width(TIMER_TICKS);

    logic [TW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= TW'(TIMER_TICKS - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: turns hit/miss events into score counter pulses, counts
// balls, and paces rounds with the inter-round timer.
module game_ctrl
    import game_pkg::*;
#(
    parameter int         BALLS       = 3,
    parameter int         TIMER_TICKS = 200_000_000,
    parameter logic [3:0] WIN_DIG1    = BCD_NINE,
    parameter logic [3:0] WIN_DIG0    = BCD_NINE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    output logic       d_inc,
    output logic       d_clr,
    output logic       ball_still,
    output logic [1:0] balls_left,
    output logic [1:0] game_state,
    output logic       gover
);

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_balls;
    logic [1:0] w_balls_next;
    logic       r_d_inc;
    logic       r_d_clr;
    logic       w_d_inc_next;
    logic       w_d_clr_next;
    logic       w_timer_load;
    logic       w_timer_done;
    logic       w_saturated;
    logic       w_win;

    game_timer #(
        .TIMER_TICKS (TIMER_TICKS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_timer_load),
        .done  (w_timer_done)
    );

    // Non-BCD digits can never match, even if a win parameter were out of range.
    assign w_saturated = (dig1 == BCD_NINE) && (dig0 == BCD_NINE);
    assign w_win       = (dig1 <= BCD_NINE) && (dig0 <= BCD_NINE) &&
                         (dig1 == WIN_DIG1) && (dig0 == WIN_DIG0);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_balls_next = r_balls;
        w_d_inc_next = 1'b0;
        w_d_clr_next = 1'b0;
        w_timer_load = 1'b0;
        case (r_state)
            NEWGAME: begin
                if (btn != 2'b00) begin
                    w_next_state = PLAY;
                    w_d_clr_next = 1'b1;
                    w_balls_next = BALLS_INIT;
                end
            end
            PLAY: begin
                w_d_inc_next = hit && !w_saturated;
                // A win outranks a simultaneous miss: the ball is not charged.
                if (w_win) begin
                    w_next_state = OVER;
                    w_timer_load = 1'b1;
                end else if (miss) begin
                    w_timer_load = 1'b1;
                    if (r_balls > 2'd1) begin
                        w_balls_next = r_balls - 2'd1;
                        w_next_state = NEWBALL;
                    end else begin
                        w_balls_next = 2'd0;
                        w_next_state = OVER;
                    end
                end
            end
            NEWBALL: begin
                // Requiring a released button keeps a held button from skipping the pause.
                if (w_timer_done && (btn == 2'b00)) begin
                    w_next_state = PLAY;
                end
            end
            OVER: begin
                if (w_timer_done) begin
                    w_next_state = NEWGAME;
                end
            end
            default: w_next_state = NEWGAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= NEWGAME;
            r_balls <= BALLS_INIT;
            r_d_inc <= 1'b0;
            r_d_clr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_balls <= w_balls_next;
            r_d_inc <= w_d_inc_next;
            r_d_clr <= w_d_clr_next;
        end
    end

    assign d_inc      = r_d_inc;
    assign d_clr      = r_d_clr;
    assign ball_still = (r_state != PLAY);
    assign balls_left = r_balls;
    assign game_state = r_state;
    assign gover      = (r_state == OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with a BCD score counter stand-in in the
// feedback loop; d_inc expectations flow through a scoreboard queue.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int TT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic       d_inc;
    logic       d_clr;
    logic       ball_still;
    logic [1:0] balls_left;
    logic [1:0] game_state;
    logic       gover;

    logic [7:0] score;
    logic       ld_req;
    logic [7:0] ld_val;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_state;
    logic       exp_inc_q[$];
    string      phase;

    typedef struct {
        logic       rst_n;
        logic [1:0] btn;
        logic       hit;
        logic       miss;
        logic [1:0] st;
        logic [1:0] balls;
        logic       still;
        logic       gov;
        logic       clr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    game_ctrl #(
        .BALLS       (3),
        .TIMER_TICKS (TT),
        .WIN_DIG1    (4'd9),
        .WIN_DIG0    (4'd9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .hit        (hit),
        .miss       (miss),
        .dig0       (dig0),
        .dig1       (dig1),
        .d_inc      (d_inc),
        .d_clr      (d_clr),
        .ball_still (ball_still),
        .balls_left (balls_left),
        .game_state (game_state),
        .gover      (gover)
    );

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        if (s[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (s[7:4] == 4'd9) ? 4'd0 : s[7:4] + 4'd1;
        end else begin
            r[3:0] = s[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Stand-in for the external two-digit BCD score counter.
    always @(posedge clk) begin
        if (ld_req)     score <= ld_val;
        else if (d_clr) score <= 8'h00;
        else if (d_inc) score <= bcd_inc(score);
    end
    assign dig1 = score[7:4];
    assign dig0 = score[3:0];

    function automatic vec_t mkv(input logic r, input logic [1:0] b, input logic h,
                                 input logic m, input logic [1:0] st, input logic [1:0] bl,
                                 input logic still, input logic gov, input logic clr);
        vec_t v;
        v.rst_n = r; v.btn = b; v.hit = h; v.miss = m;
        v.st = st; v.balls = bl; v.still = still; v.gov = gov; v.clr = clr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic [1:0] st, input logic [1:0] bl,
                            input logic still, input logic gov, input logic clr);
        check({name, ".state"}, 32'(game_state), 32'(st));
        check({name, ".balls"}, 32'(balls_left), 32'(bl));
        check({name, ".still"}, 32'(ball_still), 32'(still));
        check({name, ".gover"}, 32'(gover), 32'(gov));
        check({name, ".d_clr"}, 32'(d_clr), 32'(clr));
        exp_state = st;
    endtask

    // One clock: drive inputs, record the d_inc this cycle must produce, then
    // compare it one edge later.
    task automatic step(input logic [1:0] b, input logic h, input logic m);
        btn  = b;
        hit  = h;
        miss = m;
        exp_inc_q.push_back(reset && h && (exp_state == PLAY) && (score != 8'h99));
        @(posedge clk);
        #1;
        check({phase, ".d_inc"}, 32'(d_inc), 32'(exp_inc_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0;
        ld_req = 1'b0; ld_val = 8'h37; exp_state = NEWGAME;

        vecs.push_back(mkv(1'b0, 2'b00, 1'b0, 1'b0, NEWGAME, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 2'b00, 1'b0, 1'b0, NEWGAME, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 2'b01, 1'b0, 1'b0, PLAY,    2'd3, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 2'b00, 1'b0, 1'b0, PLAY,    2'd3, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mkv(1'b1, 2'b00, 1'b1, 1'b0, PLAY, 2'd3, 1'b0, 1'b0, 1'b0));
            vecs.push_back(mkv(1'b1, 2'b00, 1'b0, 1'b0, PLAY, 2'd3, 1'b0, 1'b0, 1'b0));
            vecs.push_back(mkv(1'b1, 2'b00, 1'b0, 1'b0, PLAY, 2'd3, 1'b0, 1'b0, 1'b0));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            phase  = $sformatf("vec%0d", i);
            reset  = vecs[i].rst_n;
            ld_req = (i == 0);
            step(vecs[i].btn, vecs[i].hit, vecs[i].miss);
            chk_outs(phase, vecs[i].st, vecs[i].balls, vecs[i].still, vecs[i].gov, vecs[i].clr);
        end
        ld_req = 1'b0;
        check("score_after_hits", 32'(score), 32'h05);

        // Three misses: two pauses in NEWBALL, then OVER with hits/buttons ignored.
        for (int r = 0; r < 3; r++) begin
            phase = $sformatf("miss%0d", r);
            step(2'b00, 1'b0, 1'b1);
            if (r < 2) chk_outs(phase, NEWBALL, 2'(2 - r), 1'b1, 1'b0, 1'b0);
            else       chk_outs(phase, OVER,    2'd0,      1'b1, 1'b1, 1'b0);
            for (int k = 1; k < TT; k++) begin
                step((r == 2 && (k == 4 || k == 5)) ? 2'b01 : 2'b00, (r == 2 && k < 4), 1'b0);
            end
            if (r < 2) chk_outs({phase, ".wait"}, NEWBALL, 2'(2 - r), 1'b1, 1'b0, 1'b0);
            else       chk_outs({phase, ".wait"}, OVER,    2'd0,      1'b1, 1'b1, 1'b0);
            step(2'b00, 1'b0, 1'b0);
            if (r < 2) chk_outs({phase, ".exit"}, PLAY,    2'(2 - r), 1'b0, 1'b0, 1'b0);
            else       chk_outs({phase, ".exit"}, NEWGAME, 2'd0,      1'b1, 1'b0, 1'b0);
        end
        check("score_retained", 32'(score), 32'h05);

        // A held button keeps NEWBALL past expiry; release resumes play.
        phase = "hold";
        step(2'b01, 1'b0, 1'b0);
        chk_outs("hold.start", PLAY, 2'd3, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk_outs("hold.miss", NEWBALL, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step(2'b10, (k == 3), 1'b0);
        chk_outs("hold.held", NEWBALL, 2'd2, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk_outs("hold.release", PLAY, 2'd2, 1'b0, 1'b0, 1'b0);

        // Win at 99: last increment, then saturation and win-over-miss priority.
        phase  = "win";
        ld_req = 1'b1; ld_val = 8'h98;
        step(2'b00, 1'b0, 1'b0);
        ld_req = 1'b0;
        chk_outs("win.load", PLAY, 2'd2, 1'b0, 1'b0, 1'b0);
        check("win.score98", 32'(score), 32'h98);
        step(2'b00, 1'b1, 1'b0);
        chk_outs("win.hit", PLAY, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk_outs("win.at99", PLAY, 2'd2, 1'b0, 1'b0, 1'b0);
        check("win.score99", 32'(score), 32'h99);
        step(2'b00, 1'b1, 1'b1);
        chk_outs("win.over", OVER, 2'd2, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < TT; k++) step(2'b00, 1'b0, 1'b0);
        chk_outs("win.wait", OVER, 2'd2, 1'b1, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk_outs("win.newgame", NEWGAME, 2'd2, 1'b1, 1'b0, 1'b0);
        check("win.score_kept", 32'(score), 32'h99);

        // Simultaneous hit+miss, then reset in the middle of the pause.
        phase  = "hm";
        ld_req = 1'b1; ld_val = 8'h00;
        step(2'b00, 1'b0, 1'b0);
        ld_req = 1'b0;
        step(2'b01, 1'b0, 1'b0);
        chk_outs("hm.start", PLAY, 2'd3, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk_outs("hm.miss1", NEWBALL, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < TT; k++) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk_outs("hm.back", PLAY, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk_outs("hm.both", NEWBALL, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        step(2'b01, 1'b0, 1'b0);
        chk_outs("hm.reset", NEWGAME, 2'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) step(2'b00, 1'b0, 1'b0);
        chk_outs("hm.idle", NEWGAME, 2'd3, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer that drives the two-digit BCD score counter's d_inc and d_clr controls from ball hit/miss events.
- Tracks remaining balls, detects game-over by ball exhaustion or by reaching the win score, and holds the ball between rounds with a fixed delay.
- Sits between the ball/paddle logic, the push buttons, the score counter and the display/text overlay.

Parameters:
- BALLS, 3, balls per game; range 1..3.
- TIMER_TICKS, 200_000_000, inter-round delay in clk cycles; must be >= 2.
- WIN_DIG1, 9, BCD tens digit of the winning score.
- WIN_DIG0, 9, BCD units digit of the winning score.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn  in  2  start/continue buttons, level; any nonzero value counts as pressed
- hit  in  1  one-cycle pulse: ball struck the paddle
- miss  in  1  one-cycle pulse: ball passed the paddle
- dig0  in  4  score units digit, fed back from the score counter
- dig1  in  4  score tens digit, fed back from the score counter
- d_inc  out  1  registered one-cycle score increment pulse
- d_clr  out  1  registered one-cycle score clear pulse
- ball_still  out  1  hold the ball at its start position
- balls_left  out  2  balls remaining in the current game
- game_state  out  2  current state encoding, for the text overlay
- gover  out  1  high while in OVER

Behaviour:
- Reset:
  - reset=0 sampled at a clk edge -> state NEWGAME, balls_left=BALLS, d_inc=0, d_clr=0, ball_still=1, gover=0, timer cleared.
  - Reset dominates every other input in that cycle.
  - Applied mid-game it aborts any running timer.
- States: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.
- NEWGAME:
  - ball_still=1.
  - btn!=0 -> PLAY; d_clr=1 in the following cycle; balls_left reloads to BALLS.
- PLAY:
  - ball_still=0.
  - hit=1 -> d_inc=1 in the next cycle. Latency is exactly 1 clk; one pulse per hit.
  - Saturation: d_inc is suppressed when {dig1,dig0}==8'h99, so the counter never wraps 99->00.
  - Win: {dig1,dig0}=={WIN_DIG1,WIN_DIG0} in any PLAY cycle -> OVER, timer loaded, balls_left unchanged.
  - Miss, balls_left>1 -> balls_left-1, -> NEWBALL, timer loaded.
  - Miss, balls_left==1 -> balls_left=0, -> OVER, timer loaded.
  - hit and miss in the same cycle: d_inc is still issued (subject to saturation) and the miss is processed as above.
  - Win and miss in the same cycle: win takes priority; balls_left is not decremented.
- NEWBALL:
  - ball_still=1.
  - Exit to PLAY only when the timer has expired AND btn==0. This prevents a held button from skipping the pause.
  - hit/miss ignored.
- OVER:
  - gover=1, ball_still=1.
  - On timer expiry -> NEWGAME.
  - Score is not cleared here; it stays displayed until the next start.
  - hit/miss/btn ignored.
- Timer:
  - Down-counter of width $clog2(TIMER_TICKS).
  - Loaded with TIMER_TICKS-1 on the transition into NEWBALL or OVER.
  - Decrements each cycle; done when it reaches 0 and holds at 0.
  - Expiry is observed TIMER_TICKS cycles after entry.
- Output timing and widths:
  - d_inc and d_clr are never high in the same cycle.
  - All outputs are registered or decoded from registered state only; no combinational path from hit, miss or btn to any output.
  - balls_left never underflows.
  - dig inputs are trusted BCD; values above 9 are never compared as a win.

Decomposition:
- Package game_pkg:
  - state localparams NEWGAME/PLAY/NEWBALL/OVER (2-bit)
  - BCD constant 4'd9
  - a function returning the timer width from TIMER_TICKS
- One sub-module, game_timer:
  - Inputs: clk, reset, load.
  - Output: done.
  - Parameterised by TIMER_TICKS.
- game_ctrl holds the FSM, the ball count and the pulse registers.
- The score counter is instantiated by the parent, not inside game_ctrl.

Test Plan:
All scenarios use BALLS=3, TIMER_TICKS=8, WIN=99.
- Reset released, btn=2'b01 for 1 cycle -> d_clr=1 exactly one cycle later, game_state=PLAY, balls_left=3, ball_still=0.
- In PLAY, 5 single hit pulses 3 cycles apart -> 5 d_inc pulses, each 1 clk after its hit; the counter reads dig1=0, dig0=5.
- Three misses, each followed by an 8-cycle wait with btn=0 -> balls_left 2 then 1 then 0. The first two misses go to NEWBALL and back to PLAY on the 8th cycle; the third goes to OVER with gover=1, then NEWGAME 8 cycles later, score retained.
- In NEWBALL with btn held at 2'b10 -> stays in NEWBALL past timer expiry; release btn -> PLAY on the next edge.
- Score driven to 98, then hit -> d_inc, score becomes 99, OVER on the next cycle. A further hit while dig=99 -> no d_inc.
- Simultaneous hit+miss with balls_left=2 -> d_inc pulse, balls_left=1, NEWBALL. Then reset=0 for 1 cycle mid-timer -> NEWGAME, balls_left=3, all outputs at reset values.
